// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronizes and debounces NB_BTN raw buttons, emitting one load pulse per confirmed press.
// Ports: clock (rising edge), i_reset (async, active-low), i_btn_raw (raw bouncing pads),
//        o_btn_pulse (registered one-cycle press pulse), o_btn_level (registered debounced level).
// Option: define BTN_ONEHOT_EN to limit o_btn_pulse to the lowest-index channel qualifying on an edge.
module btn_debouncer #(
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn_raw,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t            state [NB_BTN];
  logic [CW-1:0]     cnt   [NB_BTN];
  logic [NB_BTN-1:0] ff1, ff2, qual, grant;
  always_comb begin
    for (int i = 0; i < NB_BTN; i++)
      qual[i] = state[i] == PRESS_WAIT && ff2[i] && cnt[i] == LAST;
`ifdef BTN_ONEHOT_EN
    // lowest set bit only; losing channels still reach HELD and forfeit their press
    grant = qual & (~qual + NB_BTN'(1));
`else
    grant = qual;
`endif
  end
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      ff1         <= '0;
      ff2         <= '0;
      o_btn_pulse <= '0;
      o_btn_level <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      ff1         <= i_btn_raw;
      ff2         <= ff1;
      o_btn_pulse <= grant;
      for (int i = 0; i < NB_BTN; i++) begin
        case (state[i])
          IDLE:
            if (ff2[i]) begin
              state[i] <= PRESS_WAIT;
              cnt[i]   <= '0;
            end
          PRESS_WAIT:
            if (!ff2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST) begin
              state[i]       <= HELD;
              cnt[i]         <= '0;
              o_btn_level[i] <= 1'b1;
            end else cnt[i] <= cnt[i] + CW'(1);
          HELD:
            if (!ff2[i]) begin
              state[i] <= RELEASE_WAIT;
              cnt[i]   <= '0;
            end
          RELEASE_WAIT:
            if (ff2[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST) begin
              state[i]       <= IDLE;
              cnt[i]         <= '0;
              o_btn_level[i] <= 1'b0;
            end else cnt[i] <= cnt[i] + CW'(1);
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed and random checks of btn_debouncer against a streak-length reference model.
module tb_btn_debouncer;
  localparam int NB = 3;
  localparam int N  = 4;
  logic          clock = 1'b0;
  logic          i_reset = 1'b0;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] pulse, level;
  int            n_assert = 0, n_fail = 0;
  logic [NB-1:0] q[$];
  logic [NB-1:0] lvl_m, pul_m, prev_lvl, pseen, r;
  int            run[NB], pcount[NB], pedge[NB], fedge[NB];
  int            edge_n = 0, e;
  btn_debouncer #(.NB_BTN(NB), .DEBOUNCE_CYCLES(N)) dut (
    .clock(clock), .i_reset(i_reset), .i_btn_raw(raw),
    .o_btn_pulse(pulse), .o_btn_level(level)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    q.delete();
    q.push_back('0);
    q.push_back('0);
    lvl_m = '0;
    pul_m = '0;
    prev_lvl = '0;
    for (int i = 0; i < NB; i++) run[i] = 0;
  endtask
  // Model: the level flips once the synchronized input has disagreed with it for N+1 consecutive edges.
  task automatic step(input logic [NB-1:0] rv);
    logic [NB-1:0] s, rise;
    @(negedge clock);
    raw = rv;
    @(posedge clock);
    edge_n++;
    s = q[0];
    rise = '0;
    for (int i = 0; i < NB; i++) begin
      run[i] = (s[i] != lvl_m[i]) ? run[i] + 1 : 0;
      if (run[i] == N + 1) begin
        lvl_m[i] = ~lvl_m[i];
        run[i] = 0;
        rise[i] = lvl_m[i];
      end
    end
`ifdef BTN_ONEHOT_EN
    pul_m = rise & (~rise + NB'(1));
`else
    pul_m = rise;
`endif
    q.push_back(rv);
    void'(q.pop_front());
    #1;
    chk("pulse", 32'(pulse), 32'(pul_m));
    chk("level", 32'(level), 32'(lvl_m));
    pseen |= pulse;
    for (int i = 0; i < NB; i++) begin
      if (pulse[i]) begin
        pcount[i]++;
        pedge[i] = edge_n;
      end
      if (prev_lvl[i] && !level[i]) fedge[i] = edge_n;
    end
    prev_lvl = level;
  endtask
  task automatic clr;
    pseen = '0;
    for (int i = 0; i < NB; i++) begin
      pcount[i] = 0;
      pedge[i] = -1;
      fedge[i] = -1;
    end
  endtask
  initial begin
    clr();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_pulse", 32'(pulse), 0);
    chk("reset_level", 32'(level), 0);
    #1 i_reset = 1'b1;
    repeat (5) step('0);
    // clean press then long hold: single pulse, 6 edges after the first sample
    clr();
    e = edge_n + 1;
    repeat (110) step(3'b001);
    chk("press_edge", pedge[0], e + 6);
    chk("press_count", pcount[0], 1);
    e = edge_n + 1;
    repeat (20) step('0);
    chk("release_edge", fedge[0], e + 6);
    chk("release_nopulse", pcount[0], 1);
    // bounce on channel 1
    clr();
    step(3'b010); step('0); step(3'b010); step('0);
    e = edge_n + 1;
    repeat (20) step(3'b010);
    chk("bounce_edge", pedge[1], e + 6);
    chk("bounce_count", pcount[1], 1);
    repeat (20) step('0);
    // short glitch on channel 2
    clr();
    repeat (3) step(3'b100);
    repeat (20) step('0);
    chk("glitch_count", pcount[2], 0);
    // simultaneous press of channels 0 and 2
    clr();
    repeat (12) step(3'b101);
`ifdef BTN_ONEHOT_EN
    chk("simul_pulse", 32'(pseen), 32'(3'b001));
`else
    chk("simul_pulse", 32'(pseen), 32'(3'b101));
`endif
    chk("simul_level", 32'(level), 32'(3'b101));
    repeat (20) step('0);
    // async reset while channel 0 is mid-count and channel 1 is held
    repeat (10) step(3'b010);
    repeat (5) step(3'b011);
    #2 i_reset = 1'b0;
    #1;
    chk("async_pulse", 32'(pulse), 0);
    chk("async_level", 32'(level), 0);
    repeat (2) @(posedge clock);
    #2 i_reset = 1'b1;
    model_reset();
    clr();
    e = edge_n + 1;
    repeat (12) step(3'b011);
    chk("post_reset_edge", pedge[0], e + 6);
    chk("post_reset_level", 32'(level), 32'(3'b011));
    // random bouncing runs
    r = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      step(r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
